// File: rtl/i2c_temp_target.sv
// I2C target that serves a two-byte temperature reading and accepts writes.
// Ports: CLK/RST (sync, active-high); scl_in/sda_in raw bus inputs;
//   sda_oe open-drain pull-down; temp_msb/temp_lsb data to serve;
//   busy while addressed; rd_done on read NACK; wr_data/wr_valid
//   for each byte received in a write transfer.
module i2c_temp_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] temp_msb,
  input  logic [7:0] temp_lsb,
  output logic       busy,
  output logic       rd_done,
  output logic [7:0] wr_data,
  output logic       wr_valid
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    TX_BYTE,
    TX_ACK,
    RX_BYTE,
    RX_ACK,
    IGNORE
  } state_t;

  // Two synchronizer stages plus one history stage per bus line
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall;
  logic w_start, w_stop;
  logic w_sda;

  assign w_sda      = r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SDA edges only count as START/STOP while SCL is stable high
  assign w_start = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  state_t      r_state, w_state_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic [7:0]  r_shift, w_shift_n;
  logic        r_rw, w_rw_n;
  logic [15:0] r_hold, w_hold_n;
  logic        r_sel, w_sel_n;
  logic        r_sda_oe, w_sda_oe_n;
  logic        r_busy, w_busy_n;
  logic        r_rd_done, w_rd_done_n;
  logic [7:0]  r_wr_data, w_wr_data_n;
  logic        r_wr_valid, w_wr_valid_n;

  logic [7:0]  w_tx_byte;
  logic        w_tx_bit;

  // r_sel picks which half of the snapshot is on the wire
  assign w_tx_byte = r_sel ? r_hold[7:0] : r_hold[15:8];
  // r_cnt counts bits already driven, so the next is bit 7-r_cnt
  assign w_tx_bit  = w_tx_byte[3'd7 - r_cnt[2:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_hold     <= 16'h0000;
      r_sel      <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_done  <= 1'b0;
      r_wr_data  <= 8'h00;
      r_wr_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
      r_rw       <= w_rw_n;
      r_hold     <= w_hold_n;
      r_sel      <= w_sel_n;
      r_sda_oe   <= w_sda_oe_n;
      r_busy     <= w_busy_n;
      r_rd_done  <= w_rd_done_n;
      r_wr_data  <= w_wr_data_n;
      r_wr_valid <= w_wr_valid_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_shift_n    = r_shift;
    w_rw_n       = r_rw;
    w_hold_n     = r_hold;
    w_sel_n      = r_sel;
    w_sda_oe_n   = r_sda_oe;
    w_busy_n     = r_busy;
    w_rd_done_n  = 1'b0;
    w_wr_data_n  = r_wr_data;
    w_wr_valid_n = 1'b0;

    if (w_stop) begin
      w_state_n  = IDLE;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else if (w_start) begin
      // Plain and repeated START both restart address reception
      w_state_n  = ADDR;
      w_cnt_n    = 4'd0;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end

        ADDR: begin
          if (w_scl_rise && r_cnt < 4'd8) begin
            w_shift_n = {r_shift[6:0], w_sda};
            w_cnt_n   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_shift[7:1] == DEV_ADDR) begin
              w_state_n  = ACK_ADDR;
              w_sda_oe_n = 1'b1;
              w_busy_n   = 1'b1;
              w_rw_n     = r_shift[0];
              w_sel_n    = 1'b0;
              if (r_shift[0]) begin
                w_hold_n = {temp_msb, temp_lsb};
              end
            end else begin
              w_state_n = IGNORE;
            end
          end
        end

        ACK_ADDR: begin
          if (w_scl_fall) begin
            w_cnt_n = 4'd0;
            if (r_rw) begin
              // The falling edge that ends the ACK also drives bit 7
              w_state_n  = TX_BYTE;
              w_sda_oe_n = ~r_hold[15];
              w_cnt_n    = 4'd1;
            end else begin
              w_state_n  = RX_BYTE;
              w_sda_oe_n = 1'b0;
            end
          end
        end

        TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_state_n  = TX_ACK;
              w_sda_oe_n = 1'b0;
            end else begin
              w_sda_oe_n = ~w_tx_bit;
              w_cnt_n    = r_cnt + 4'd1;
            end
          end
        end

        TX_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_state_n = TX_BYTE;
              w_sel_n   = ~r_sel;
              w_cnt_n   = 4'd0;
            end else begin
              w_state_n   = IGNORE;
              w_rd_done_n = 1'b1;
              w_busy_n    = 1'b0;
            end
          end
        end

        RX_BYTE: begin
          if (w_scl_rise && r_cnt < 4'd8) begin
            w_shift_n = {r_shift[6:0], w_sda};
            w_cnt_n   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_wr_data_n  = {r_shift[6:0], w_sda};
              w_wr_valid_n = 1'b1;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_state_n  = RX_ACK;
            w_sda_oe_n = 1'b1;
          end
        end

        RX_ACK: begin
          if (w_scl_fall) begin
            w_state_n  = RX_BYTE;
            w_sda_oe_n = 1'b0;
            w_cnt_n    = 4'd0;
          end
        end

        IGNORE: begin
        end
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign rd_done  = r_rd_done;
  assign wr_data  = r_wr_data;
  assign wr_valid = r_wr_valid;

endmodule
